mpsoc_gpio_debouncer: RTL and testbench

//   Input conditioning stage directly upstream of mpsoc_wb_gpio. Synchronises raw asynchronous
//   pad levels into the wb_clk_i domain and filters glitches with a per-bit stability counter.
//   pad_o drives mpsoc_wb_gpio ext_pad_i. rise_o and fall_o give one-cycle edge pulses for

---
 rtl/mpsoc_gpio_debouncer_if.sv | 30 +++
 rtl/mpsoc_gpio_debouncer.sv | 97 +++++++++
 tb/tb_mpsoc_gpio_debouncer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_gpio_debouncer_if.sv
// Pad-side signal bundle between raw GPIO pads, the debouncer and mpsoc_wb_gpio.
// master drives the raw pads and enables; slave is the debouncer itself.
interface mpsoc_gpio_debouncer_if #(
  parameter int GPIO_WIDTH = 32
);
  logic [GPIO_WIDTH-1:0] pad_i;
  logic [GPIO_WIDTH-1:0] deb_en_i;
  logic [GPIO_WIDTH-1:0] pad_o;
  logic [GPIO_WIDTH-1:0] rise_o;
  logic [GPIO_WIDTH-1:0] fall_o;
  logic                  changed_o;

  modport master (
    output pad_i,
    output deb_en_i,
    input  pad_o,
    input  rise_o,
    input  fall_o,
    input  changed_o
  );

  modport slave (
    input  pad_i,
    input  deb_en_i,
    output pad_o,
    output rise_o,
    output fall_o,
    output changed_o
  );
endinterface

// File: rtl/mpsoc_gpio_debouncer.sv
// GPIO input conditioner: 2-flop synchroniser plus a per-bit stability filter.
// Emits registered levels and one-cycle rise/fall pulses for the Wishbone GPIO block.
module mpsoc_gpio_debouncer #(
  parameter int GPIO_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  mpsoc_gpio_debouncer_if.slave  gpio
);

  localparam int CNT_WIDTH = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $fatal(1, "mpsoc_gpio_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [GPIO_WIDTH-1:0] sync1_q;
  logic [GPIO_WIDTH-1:0] sync2_q;
  logic [GPIO_WIDTH-1:0] pad_q;
  logic [GPIO_WIDTH-1:0] pad_d;
  logic [GPIO_WIDTH-1:0] rise_q;
  logic [GPIO_WIDTH-1:0] rise_d;
  logic [GPIO_WIDTH-1:0] fall_q;
  logic [GPIO_WIDTH-1:0] fall_d;
  logic                  changed_q;
  logic                  changed_d;

  // Plain flop chain: nothing may sit between the two synchroniser stages.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio.pad_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 pad_bit_d;

    // Count consecutive samples that disagree with the accepted level; any agreement restarts.
    always_comb begin
      cnt_d     = '0;
      pad_bit_d = pad_q[gi];
      if (!gpio.deb_en_i[gi]) begin
        pad_bit_d = sync2_q[gi];
      end else if (sync2_q[gi] != pad_q[gi]) begin
        if (cnt_q >= CNT_LAST) begin
          pad_bit_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pad_d[gi] = pad_bit_d;
  end

  always_comb begin
    rise_d    = pad_d & ~pad_q;
    fall_d    = ~pad_d & pad_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pad_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      pad_q     <= pad_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign gpio.pad_o     = pad_q;
  assign gpio.rise_o    = rise_q;
  assign gpio.fall_o    = fall_q;
  assign gpio.changed_o = changed_q;

endmodule

// File: tb/tb_mpsoc_gpio_debouncer.sv
// Scoreboard bench for mpsoc_gpio_debouncer: a sliding-window reference model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_mpsoc_gpio_debouncer;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mpsoc_gpio_debouncer_if #(.GPIO_WIDTH(W)) gpio ();

  mpsoc_gpio_debouncer #(
    .GPIO_WIDTH      (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .gpio     (gpio.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pad;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a bit flips once its last D synchronised samples all
  // disagree with the current level; bypassed bits copy the sample.
  logic [W-1:0] m_s1, m_s2, m_pad;
  logic [W-1:0] m_hist[$];

  always @(posedge clk) begin
    exp_t         e;
    logic [W-1:0] s;
    logic [W-1:0] nw;
    bit           all_diff;
    cyc++;
    if (rst) begin
      m_s1  = '0;
      m_s2  = '0;
      m_pad = '0;
      m_hist.delete();
      for (int k = 0; k < D; k++) m_hist.push_back('0);
      e = '{pad: '0, rise: '0, fall: '0, chg: 1'b0};
    end else begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = gpio.pad_i;
      m_hist.push_back(s);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      for (int i = 0; i < W; i++) begin
        if (!gpio.deb_en_i[i]) begin
          nw[i] = s[i];
        end else begin
          all_diff = (m_hist.size() == D);
          foreach (m_hist[k]) if (m_hist[k][i] == m_pad[i]) all_diff = 0;
          nw[i] = all_diff ? ~m_pad[i] : m_pad[i];
        end
      end
      e.pad  = nw;
      e.rise = nw & ~m_pad;
      e.fall = ~nw & m_pad;
      e.chg  = (e.rise | e.fall) != '0;
      m_pad  = nw;
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: falling edge pops the scoreboard; a reset rising mid-cycle (clk high)
  // checks that every output clears immediately.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (clk) begin
        #1;
        check("async_rst_pad",  gpio.pad_o,  '0);
        check("async_rst_rise", gpio.rise_o, '0);
        check("async_rst_fall", gpio.fall_o, '0);
        check("async_rst_chg",  W'(gpio.changed_o), '0);
        $display("cyc %0d async reset: pad_o=%h", cyc, gpio.pad_o);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rst) e = '{pad: '0, rise: '0, fall: '0, chg: 1'b0};
        check("pad_o",     gpio.pad_o,  e.pad);
        check("rise_o",    gpio.rise_o, e.rise);
        check("fall_o",    gpio.fall_o, e.fall);
        check("changed_o", W'(gpio.changed_o), W'(e.chg));
        if (e.chg)
          $display("cyc %0d pad_o=%h rise=%h fall=%h", cyc, gpio.pad_o, gpio.rise_o, gpio.fall_o);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    gpio.pad_i    = '1;
    gpio.deb_en_i = '1;
    // Pins high through reset release.
    tick(3);
    rst = 1'b0;
    tick(10);

    // Clean rising edge on bit 0.
    gpio.pad_i = '0;
    tick(10);
    gpio.pad_i[0] = 1'b1;
    tick(10);

    // Glitch on bit 3: 3 cycles rejected, 4 cycles accepted.
    gpio.pad_i[3] = 1'b1; tick(3);
    gpio.pad_i[3] = 1'b0; tick(10);
    gpio.pad_i[3] = 1'b1; tick(4);
    gpio.pad_i[3] = 1'b0; tick(12);

    // Restart on bit 5: high 3, low 1, then held high.
    gpio.pad_i[5] = 1'b1; tick(3);
    gpio.pad_i[5] = 1'b0; tick(1);
    gpio.pad_i[5] = 1'b1; tick(10);

    // Bit 0 bypassed, bit 8 debounced, then bit 8 switched to bypass mid-count.
    gpio.pad_i    = '0;
    gpio.deb_en_i = '1;
    tick(10);
    gpio.deb_en_i = 32'hFFFF_FF00;
    gpio.pad_i    = 32'h0000_0101;
    tick(10);
    gpio.pad_i    = 32'h0000_0000;
    tick(3);
    gpio.deb_en_i[8] = 1'b0;
    tick(5);
    gpio.deb_en_i = '1;
    tick(8);

    // Asynchronous reset while bit 1 is mid-count.
    gpio.pad_i = '0;
    tick(10);
    gpio.pad_i[1] = 1'b1;
    tick(4);
    rst = 1'b1;
    gpio.pad_i = '0;
    tick(2);
    rst = 1'b0;
    tick(12);

    // Randomised phase: alternating glitchy and slow segments, random enables.
    for (int c = 0; c < 800; c++) begin
      if (c % 64 == 0) gpio.deb_en_i = $urandom | $urandom;
      if ((c / 100) % 2 == 0)
        gpio.pad_i = gpio.pad_i ^ ($urandom & $urandom & $urandom);
      else if ($urandom_range(0, 9) == 0)
        gpio.pad_i = gpio.pad_i ^ ($urandom & $urandom);
      if (c == 400) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      tick(1);
    end
    gpio.pad_i = '0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
